mtxmul_seq_ctrl: RTL

- Loop sequencer for the 8x8 matrix-multiply engine: C[row][col] = sum over k of A[row][k]*B[k][col].
- Drives the i/j/k index chain, issues operand reads, and tags the MAC pipeline with clear/enable/last.
- Emits result writes and a done pulse.
- Sits between the AXI-lite command registers (START/DONE) and the operand BRAMs + MAC datapath.

---
 rtl/mtxmul_pkg.sv | 31 +++
 rtl/mtxmul_tag_pipe.sv | 38 +++
 rtl/mtxmul_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mtxmul_pkg.sv
// Shared types for the matrix-multiply loop sequencer.
// Optional perf counters are enabled with MTXMUL_PERF_CNT_EN.
package mtxmul_pkg;

  localparam int DIM_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Tag layout, MSB first: {valid, first, last, row, col}
  function automatic int tag_w(input int dim_w);
    return 3 + 2 * dim_w;
  endfunction

  function automatic int tag_vld(input int dim_w);
    return 2 + 2 * dim_w;
  endfunction

  function automatic int tag_first(input int dim_w);
    return 1 + 2 * dim_w;
  endfunction

  function automatic int tag_last(input int dim_w);
    return 2 * dim_w;
  endfunction

endpackage

// File: rtl/mtxmul_tag_pipe.sv
// Fixed-latency tag shift register that tracks operand reads in flight.
// o_any_vld is high while any stage carries a valid tag.
module mtxmul_tag_pipe
  import mtxmul_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  parameter int VLD   = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag,
  output logic         o_any_vld
);

  logic [W-1:0] r_stg [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_stg[i] <= '0;
    end else begin
      r_stg[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++)
        r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_tag = r_stg[DEPTH-1];

  always_comb begin
    o_any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      o_any_vld = o_any_vld | r_stg[i][VLD];
  end

endmodule

// File: rtl/mtxmul_seq_ctrl.sv
// i/j/k loop sequencer for the matrix-multiply engine.
// Define MTXMUL_PERF_CNT_EN to add busy/stall cycle counters.
module mtxmul_seq_ctrl
  import mtxmul_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STALL,
  output logic               BUSY,
  output logic               DONE,
  output logic               RD_EN,
  output logic [DIM_W-1:0]   ROW_IDX,
  output logic [DIM_W-1:0]   COL_IDX,
  output logic [DIM_W-1:0]   K_IDX,
  output logic               MAC_EN,
  output logic               MAC_CLR,
  output logic               WR_EN,
  output logic [2*DIM_W-1:0] WR_ADDR
`ifdef MTXMUL_PERF_CNT_EN
  ,
  output logic [31:0]        PERF_BUSY_CYC,
  output logic [31:0]        PERF_STALL_CYC
`endif
);

  localparam int TW    = tag_w(DIM_W);
  localparam int VLD   = tag_vld(DIM_W);
  localparam int FIRST = tag_first(DIM_W);
  localparam int LAST  = tag_last(DIM_W);
  localparam logic [DIM_W-1:0] IDX_ONE =
    {{(DIM_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_nxt;
  logic [DIM_W-1:0]   r_row;
  logic [DIM_W-1:0]   r_col;
  logic [DIM_W-1:0]   r_k;
  logic               w_issue;
  logic               w_last_iss;
  logic [TW-1:0]      w_tag_in;
  logic [TW-1:0]      w_tag_out;
  logic               w_any_vld;
  logic               w_wr;
  logic               r_wr_en;
  logic [2*DIM_W-1:0] r_wr_addr;

  assign w_issue    = (r_state == RUN) & ~STALL;
  assign w_last_iss = w_issue & (&{r_row, r_col, r_k});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (START)
          w_nxt = RUN;
      end
      RUN: begin
        BUSY = 1'b1;
        if (w_last_iss)
          w_nxt = DRAIN;
      end
      DRAIN: begin
        BUSY = 1'b1;
        if (!w_any_vld)
          w_nxt = FIN;
      end
      FIN: begin
        DONE  = 1'b1;
        w_nxt = IDLE;
      end
    endcase
  end

  // k fastest, then col, then row; all wrap to 0 after the last issue
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else if (w_issue) begin
      r_k <= r_k + IDX_ONE;
      if (&r_k) begin
        r_col <= r_col + IDX_ONE;
        if (&r_col)
          r_row <= r_row + IDX_ONE;
      end
    end
  end

  assign RD_EN   = w_issue;
  assign ROW_IDX = r_row;
  assign COL_IDX = r_col;
  assign K_IDX   = r_k;

  assign w_tag_in = {w_issue, (r_k == '0), (&r_k), r_row, r_col};

  mtxmul_tag_pipe #(
    .W     (TW),
    .DEPTH (RD_LAT),
    .VLD   (VLD)
  ) u_tag_pipe (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_tag     (w_tag_in),
    .o_tag     (w_tag_out),
    .o_any_vld (w_any_vld)
  );

  assign MAC_EN  = w_tag_out[VLD];
  assign MAC_CLR = w_tag_out[VLD] & w_tag_out[FIRST];
  assign w_wr    = w_tag_out[VLD] & w_tag_out[LAST];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en   <= w_wr;
      r_wr_addr <= w_wr ? w_tag_out[2*DIM_W-1:0] : '0;
    end
  end

  assign WR_EN   = r_wr_en;
  assign WR_ADDR = r_wr_addr;

`ifdef MTXMUL_PERF_CNT_EN
  logic [31:0] r_pbusy;
  logic [31:0] r_pstall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pbusy  <= '0;
      r_pstall <= '0;
    end else if ((r_state == IDLE) && START) begin
      r_pbusy  <= '0;
      r_pstall <= '0;
    end else begin
      if (BUSY && !(&r_pbusy))
        r_pbusy <= r_pbusy + 32'd1;
      if ((r_state == RUN) && STALL && !(&r_pstall))
        r_pstall <= r_pstall + 32'd1;
    end
  end

  assign PERF_BUSY_CYC  = r_pbusy;
  assign PERF_STALL_CYC = r_pstall;
`endif

endmodule
